// File: rtl/fetch_instruction_queue_if.sv
// Fetch/decode side signals of the instruction queue, grouped in one bundle.
// Latency: none; pure wiring between the queue and its neighbours.
// Backpressure: carries decodeStall_i inward and fetchStall_o/full_o outward.
interface fetch_instruction_queue_if #(
  parameter int addressSize     = 64,
  parameter int instructionSize = 32,
  parameter int queuePtrSize    = 3
);
  logic                       flushPipeline_i;
  logic                       enable_i;
  logic [instructionSize-1:0] instruction_i;
  logic [addressSize-1:0]     instructionAddress_i;
  logic                       decodeStall_i;
  logic                       enable_o;
  logic [instructionSize-1:0] instruction_o;
  logic [addressSize-1:0]     instructionAddress_o;
  logic                       fetchStall_o;
  logic                       full_o;
  logic                       overflow_o;
  logic [queuePtrSize:0]      count_o;

  // Queue side.
  modport slave (
    input  flushPipeline_i, enable_i, instruction_i, instructionAddress_i, decodeStall_i,
    output enable_o, instruction_o, instructionAddress_o, fetchStall_o, full_o,
    output overflow_o, count_o
  );

  // Fetch/decode (or bench) side.
  modport master (
    output flushPipeline_i, enable_i, instruction_i, instructionAddress_i, decodeStall_i,
    input  enable_o, instruction_o, instructionAddress_o, fetchStall_o, full_o,
    input  overflow_o, count_o
  );
endinterface

// File: rtl/fetch_instruction_queue.sv
// Circular instruction buffer between fetch and decode, presenting {instr, addr} in program order.
// Latency: a push is visible on the outputs one edge later (no bypass); pop takes effect at the edge.
// Backpressure: fetchStall_o from registered count leaves skidEntries slots; full drops and flags overflow.
module fetch_instruction_queue #(
  parameter int addressSize     = 64,
  parameter int instructionSize = 32,
  parameter int queueDepth      = 8,
  parameter int queuePtrSize    = 3,
  parameter int skidEntries     = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  fetch_instruction_queue_if.slave fiq
);

  localparam int CntW = queuePtrSize + 1;
  localparam logic [CntW-1:0] LpDepth    = CntW'(queueDepth);
  localparam logic [CntW-1:0] LpStallLvl = CntW'(queueDepth - skidEntries);

  logic [queuePtrSize-1:0]    r_head;
  logic [queuePtrSize-1:0]    r_tail;
  logic [CntW-1:0]            r_count;
  logic                       r_overflow;
  logic [instructionSize-1:0] r_instr_mem [queueDepth];
  logic [addressSize-1:0]     r_addr_mem  [queueDepth];

  logic w_vld;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Handshake decode: a pop frees a slot in the same cycle, so a full queue can still accept.
  assign w_vld  = (r_count != '0);
  assign w_full = (r_count == LpDepth);
  assign w_pop  = w_vld & ~fiq.decodeStall_i;
  assign w_push = fiq.enable_i & (~w_full | w_pop);
  assign w_drop = fiq.enable_i & w_full & ~w_pop;

  // Pointer/occupancy state; reset beats flush, and flush discards any same-cycle push or pop.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Overflow is an error record of a fetch that ignored the stall; only reset clears it.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (fiq.flushPipeline_i) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage; instruction and address are always written together into the tail slot.
  always_ff @(posedge clock_i) begin
    if (!reset_i && !fiq.flushPipeline_i && w_push) begin
      r_instr_mem[r_tail] <= fiq.instruction_i;
      r_addr_mem[r_tail]  <= fiq.instructionAddress_i;
    end
  end

  // Outputs come only from registered state; data is forced to zero while the queue is empty.
  assign fiq.enable_o             = w_vld;
  assign fiq.instruction_o        = w_vld ? r_instr_mem[r_head] : '0;
  assign fiq.instructionAddress_o = w_vld ? r_addr_mem[r_head]  : '0;
  assign fiq.fetchStall_o         = (r_count >= LpStallLvl);
  assign fiq.full_o               = w_full;
  assign fiq.overflow_o           = r_overflow;
  assign fiq.count_o              = r_count;

endmodule

// File: tb/tb_fetch_instruction_queue.sv
// Directed bench for fetch_instruction_queue: vector table plus hand-written corner sequences.
// Latency: each step drives inputs at negedge and checks outputs 1 time unit after the next posedge.
// Backpressure: decodeStall_i driven per step; fetchStall_o/full_o/overflow_o checked against hand values.
module tb_fetch_instruction_queue;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;

  always #5 clock_i = ~clock_i;

  fetch_instruction_queue_if bus ();

  fetch_instruction_queue dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .fiq     (bus)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        en;
    logic        stall;
    logic [31:0] instr;
    logic [63:0] addr;
    logic        e_en;
    logic [31:0] e_instr;
    logic [63:0] e_addr;
    logic [3:0]  e_cnt;
    logic        e_fst;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [18];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic rst, input logic flush, input logic en, input logic stall,
                              input logic [31:0] instr, input logic [63:0] addr,
                              input logic e_en, input logic [31:0] e_instr, input logic [63:0] e_addr,
                              input logic [3:0] e_cnt, input logic e_fst, input logic e_full,
                              input logic e_ovf);
    vec_t v;
    v.rst = rst; v.flush = flush; v.en = en; v.stall = stall; v.instr = instr; v.addr = addr;
    v.e_en = e_en; v.e_instr = e_instr; v.e_addr = e_addr; v.e_cnt = e_cnt;
    v.e_fst = e_fst; v.e_full = e_full; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_en, input logic [31:0] e_instr,
                         input logic [63:0] e_addr, input logic [3:0] e_cnt, input logic e_fst,
                         input logic e_full, input logic e_ovf);
    chk({tag, ".enable_o"},             64'(bus.enable_o),             64'(e_en));
    chk({tag, ".instruction_o"},        64'(bus.instruction_o),        64'(e_instr));
    chk({tag, ".instructionAddress_o"}, bus.instructionAddress_o,      e_addr);
    chk({tag, ".count_o"},              64'(bus.count_o),              64'(e_cnt));
    chk({tag, ".fetchStall_o"},         64'(bus.fetchStall_o),         64'(e_fst));
    chk({tag, ".full_o"},               64'(bus.full_o),               64'(e_full));
    chk({tag, ".overflow_o"},           64'(bus.overflow_o),           64'(e_ovf));
  endtask

  // One clock step: drive at negedge, let the posedge happen, settle before sampling.
  task automatic cyc(input logic rst, input logic flush, input logic en, input logic stall,
                     input logic [31:0] instr, input logic [63:0] addr);
    @(negedge clock_i);
    reset_i                  = rst;
    bus.flushPipeline_i      = flush;
    bus.enable_i             = en;
    bus.decodeStall_i        = stall;
    bus.instruction_i        = instr;
    bus.instructionAddress_i = addr;
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    bus.flushPipeline_i      = 1'b0;
    bus.enable_i             = 1'b0;
    bus.decodeStall_i        = 1'b0;
    bus.instruction_i        = '0;
    bus.instructionAddress_i = '0;

    // Reset, single push (A0), fill to 8 under stall, then drain in order.
    vecs[0]  = mk(H,L,L,L, 32'h0,        64'h0,    L, 32'h0,        64'h0,    4'd0, L,L,L);
    vecs[1]  = mk(L,L,H,H, 32'h38200001, 64'h1000, H, 32'h38200001, 64'h1000, 4'd1, L,L,L);
    vecs[2]  = mk(L,L,H,H, 32'h38200002, 64'h1004, H, 32'h38200001, 64'h1000, 4'd2, L,L,L);
    vecs[3]  = mk(L,L,H,H, 32'h38200003, 64'h1008, H, 32'h38200001, 64'h1000, 4'd3, L,L,L);
    vecs[4]  = mk(L,L,H,H, 32'h38200004, 64'h100C, H, 32'h38200001, 64'h1000, 4'd4, L,L,L);
    vecs[5]  = mk(L,L,H,H, 32'h38200005, 64'h1010, H, 32'h38200001, 64'h1000, 4'd5, L,L,L);
    vecs[6]  = mk(L,L,H,H, 32'h38200006, 64'h1014, H, 32'h38200001, 64'h1000, 4'd6, H,L,L);
    vecs[7]  = mk(L,L,H,H, 32'h38200007, 64'h1018, H, 32'h38200001, 64'h1000, 4'd7, H,L,L);
    vecs[8]  = mk(L,L,H,H, 32'h38200008, 64'h101C, H, 32'h38200001, 64'h1000, 4'd8, H,H,L);
    vecs[9]  = mk(L,L,L,L, 32'h0,        64'h0,    H, 32'h38200002, 64'h1004, 4'd7, H,L,L);
    vecs[10] = mk(L,L,L,L, 32'h0,        64'h0,    H, 32'h38200003, 64'h1008, 4'd6, H,L,L);
    vecs[11] = mk(L,L,L,L, 32'h0,        64'h0,    H, 32'h38200004, 64'h100C, 4'd5, L,L,L);
    vecs[12] = mk(L,L,L,L, 32'h0,        64'h0,    H, 32'h38200005, 64'h1010, 4'd4, L,L,L);
    vecs[13] = mk(L,L,L,L, 32'h0,        64'h0,    H, 32'h38200006, 64'h1014, 4'd3, L,L,L);
    vecs[14] = mk(L,L,L,L, 32'h0,        64'h0,    H, 32'h38200007, 64'h1018, 4'd2, L,L,L);
    vecs[15] = mk(L,L,L,L, 32'h0,        64'h0,    H, 32'h38200008, 64'h101C, 4'd1, L,L,L);
    vecs[16] = mk(L,L,L,L, 32'h0,        64'h0,    L, 32'h0,        64'h0,    4'd0, L,L,L);
    vecs[17] = mk(L,L,L,L, 32'h0,        64'h0,    L, 32'h0,        64'h0,    4'd0, L,L,L);

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].rst, vecs[i].flush, vecs[i].en, vecs[i].stall, vecs[i].instr, vecs[i].addr);
      chk_out($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_instr, vecs[i].e_addr,
              vecs[i].e_cnt, vecs[i].e_fst, vecs[i].e_full, vecs[i].e_ovf);
    end

    // Full queue: push+pop reuses the freed slot; push while full and stalled is dropped.
    cyc(H, L, L, L, 32'h0, 64'h0);
    for (int k = 0; k < 8; k++) begin
      cyc(L, L, H, H, 32'(32'hA000_0000 + k), 64'(64'h3000 + 4 * k));
    end
    chk_out("t3_fill", H, 32'hA000_0000, 64'h3000, 4'd8, H, H, L);
    cyc(L, L, H, L, 32'hA000_0008, 64'h3020);
    chk_out("t3_pushpop", H, 32'hA000_0001, 64'h3004, 4'd8, H, H, L);
    cyc(L, L, H, H, 32'hDEAD_BEEF, 64'h9999);
    chk_out("t3_drop", H, 32'hA000_0001, 64'h3004, 4'd8, H, H, H);
    for (int k = 1; k <= 8; k++) begin
      cyc(L, L, L, L, 32'h0, 64'h0);
      if (k < 8) begin
        chk_out($sformatf("t3_drain%0d", k), H, 32'(32'hA000_0000 + k + 1),
                64'(64'h3000 + 4 * (k + 1)), 4'(8 - k), ((8 - k) >= 6), L, H);
      end else begin
        chk_out("t3_drain8", L, 32'h0, 64'h0, 4'd0, L, L, H);
      end
    end

    // Flush at count 5 with a simultaneous push; overflow must survive the flush.
    for (int k = 0; k < 5; k++) begin
      cyc(L, L, H, H, 32'(32'hC000_0000 + k), 64'(64'h4000 + 4 * k));
    end
    chk_out("t5_pre", H, 32'hC000_0000, 64'h4000, 4'd5, L, L, H);
    cyc(L, H, H, H, 32'hC000_0005, 64'h4014);
    chk_out("t5_flush", L, 32'h0, 64'h0, 4'd0, L, L, H);
    cyc(L, L, H, H, 32'hC000_00AA, 64'h40A0);
    chk_out("t5_after", H, 32'hC000_00AA, 64'h40A0, 4'd1, L, L, H);

    // Reset together with flush at count 4 returns everything to reset values.
    for (int k = 0; k < 3; k++) begin
      cyc(L, L, H, H, 32'(32'hC000_00B0 + k), 64'(64'h40B0 + 4 * k));
    end
    chk_out("t6_pre", H, 32'hC000_00AA, 64'h40A0, 4'd4, L, L, H);
    cyc(H, H, H, H, 32'h1234_5678, 64'h5000);
    chk_out("t6_reset", L, 32'h0, 64'h0, 4'd0, L, L, L);

    // Streaming push+pop for 20 cycles: pointers wrap, count holds at 1.
    cyc(L, L, H, L, 32'hB000_0000, 64'h2000);
    chk_out("t4_first", H, 32'hB000_0000, 64'h2000, 4'd1, L, L, L);
    for (int k = 1; k <= 20; k++) begin
      cyc(L, L, H, L, 32'(32'hB000_0000 + k), 64'(64'h2000 + 4 * k));
      chk_out($sformatf("t4_stream%0d", k), H, 32'(32'hB000_0000 + k),
              64'(64'h2000 + 4 * k), 4'd1, L, L, L);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
